// File: rtl/descrambler_sync_if.sv
// Beat-level bus between the block aligner, the descrambler and the 64b/66b decoder.
// master drives the receive beats and controls; slave returns the descrambled beats and lock status.
interface descrambler_sync_if #(
    parameter int DATA_W = 64
);
    logic              in_enable;
    logic              in_pop;
    logic [DATA_W-1:0] in_data;
    logic              bypass;
    logic              sync_clr;
    logic              out_pop;
    logic [DATA_W-1:0] out_data;
    logic              out_lock;
    logic              locked;

    modport master (
        output in_enable, in_pop, in_data, bypass, sync_clr,
        input  out_pop, out_data, out_lock, locked
    );

    modport slave (
        input  in_enable, in_pop, in_data, bypass, sync_clr,
        output out_pop, out_data, out_lock, locked
    );
endinterface

// File: rtl/descrambler_sync.sv
// Self-synchronous descrambler (x^TAP_B + x^TAP_A + 1) with history-fill lock tracking,
// bypass, synchronous history clear and an optional output register stage.
module descrambler_sync #(
    parameter int DATA_W  = 64,
    parameter int TAP_A   = 39,
    parameter int TAP_B   = 58,
    parameter int OUT_REG = 1
) (
    input  logic               clk,
    input  logic               reset,
    descrambler_sync_if.slave  bus
);
    localparam int EW = DATA_W + TAP_B;
    localparam int CW = $clog2(TAP_B + DATA_W + 1);
    localparam logic [CW-1:0] C_FULL = CW'(TAP_B);
    localparam logic [CW-1:0] C_STEP = CW'(DATA_W);

    logic [TAP_B-1:0]  r_h;
    logic [CW-1:0]     r_cnt;

    logic              w_accept;
    logic [TAP_B-1:0]  w_h_eff;
    logic [CW-1:0]     w_cnt_base;
    logic [CW-1:0]     w_cnt_sum;
    logic [CW-1:0]     w_cnt_next;
    logic [EW-1:0]     w_e;
    logic [DATA_W-1:0] w_desc;
    logic [DATA_W-1:0] w_out;
    logic              w_flag;

    assign w_accept = bus.in_enable & bus.in_pop;

    // A clear in the same cycle as an accept wins: the beat sees an empty history.
    assign w_h_eff    = bus.sync_clr ? '0 : r_h;
    assign w_cnt_base = bus.sync_clr ? '0 : r_cnt;
    assign w_cnt_sum  = w_cnt_base + C_STEP;
    assign w_cnt_next = (w_cnt_sum >= C_FULL) ? C_FULL : w_cnt_sum;
    assign w_flag     = (w_cnt_base == C_FULL);

    assign w_e = {bus.in_data, w_h_eff};

    always_comb begin
        w_desc = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_desc[i] = w_e[TAP_B + i] ^ w_e[TAP_B + i - TAP_A] ^ w_e[i];
        end
    end

    assign w_out = bus.bypass ? bus.in_data : w_desc;

    // History and fill count advance in bypass too, so leaving bypass needs no re-lock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h   <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_h   <= w_e[EW-1:DATA_W];
            r_cnt <= w_cnt_next;
        end else if (bus.sync_clr) begin
            r_h   <= '0;
            r_cnt <= '0;
        end
    end

    assign bus.locked = (r_cnt == C_FULL);

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              r_pop;
            logic [DATA_W-1:0] r_data;
            logic              r_lock;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_pop  <= 1'b0;
                    r_data <= '0;
                    r_lock <= 1'b0;
                end else begin
                    r_pop <= w_accept;
                    if (w_accept) begin
                        r_data <= w_out;
                        r_lock <= w_flag;
                    end
                end
            end

            assign bus.out_pop  = r_pop;
            assign bus.out_data = r_data;
            assign bus.out_lock = r_lock;
        end else begin : g_out_comb
            assign bus.out_pop  = w_accept;
            assign bus.out_data = w_out;
            assign bus.out_lock = w_flag;
        end
    endgenerate
endmodule

// File: tb/tb_descrambler_sync.sv
// Bench for descrambler_sync: a 64-bit and a 16-bit instance checked against a bit-stream
// reference model, fixed vector tables and an independent LFSR scrambler.
module tb_descrambler_sync;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    descrambler_sync_if #(.DATA_W(64)) if64 ();
    descrambler_sync_if #(.DATA_W(16)) if16 ();

    descrambler_sync #(.DATA_W(64), .TAP_A(39), .TAP_B(58), .OUT_REG(1)) u_dut64 (
        .clk(clk), .reset(reset), .bus(if64));
    descrambler_sync #(.DATA_W(16), .TAP_A(39), .TAP_B(58), .OUT_REG(1)) u_dut16 (
        .clk(clk), .reset(reset), .bus(if16));

    int n_cmp = 0;
    int n_err = 0;

    // Stream bits absorbed since reset/clear, oldest first, trimmed to the last 58.
    bit s64[$];
    bit s16[$];
    logic [63:0] hd64, hd16;
    bit          hl64, hl16;

    typedef struct {
        logic [63:0] d;
        bit          byp;
        bit          clr;
        logic [63:0] ed;
        bit          el;
        bit          elk;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Descrambled bit n = s[n] ^ s[n-39] ^ s[n-58], bits before the stream start read as 0.
    task automatic model(input int sel, input int w, input logic [63:0] din, input bit clr,
                         input bit byp, output logic [63:0] ed, output bit el);
        bit q[$];
        int n0;
        int n;
        q = (sel == 0) ? s64 : s16;
        if (clr) q.delete();
        el = (q.size() >= 58);
        for (int i = 0; i < w; i++) q.push_back(din[i]);
        n0 = q.size() - w;
        ed = '0;
        for (int i = 0; i < w; i++) begin
            n = n0 + i;
            ed[i] = q[n] ^ ((n >= 39) ? q[n-39] : 1'b0) ^ ((n >= 58) ? q[n-58] : 1'b0);
        end
        if (byp) begin
            ed = '0;
            for (int i = 0; i < w; i++) ed[i] = din[i];
        end
        while (q.size() > 58) void'(q.pop_front());
        if (sel == 0) s64 = q; else s16 = q;
    endtask

    task automatic model_reset();
        s64.delete();
        s16.delete();
        hd64 = '0; hd16 = '0;
        hl64 = 1'b0; hl16 = 1'b0;
    endtask

    task automatic run(input int sel, input bit en, input bit pop, input bit byp, input bit clr,
                       input logic [63:0] d, input string tag,
                       output logic [63:0] gd, output bit gl, output bit glk);
        int          w;
        bit          acc;
        logic [63:0] ed;
        bit          el;
        bit          ep;
        bit          elk;
        w   = (sel == 0) ? 64 : 16;
        acc = en & pop;
        if (acc) begin
            model(sel, w, d, clr, byp, ed, el);
            if (sel == 0) begin hd64 = ed; hl64 = el; end
            else          begin hd16 = ed; hl16 = el; end
        end else begin
            if (clr) begin
                if (sel == 0) s64.delete(); else s16.delete();
            end
            ed = (sel == 0) ? hd64 : hd16;
            el = (sel == 0) ? hl64 : hl16;
        end
        elk = (sel == 0) ? (s64.size() >= 58) : (s16.size() >= 58);
        @(negedge clk);
        if (sel == 0) begin
            if64.in_enable = en; if64.in_pop = pop; if64.bypass = byp;
            if64.sync_clr = clr; if64.in_data = d;
            if16.in_pop = 1'b0; if16.sync_clr = 1'b0;
        end else begin
            if16.in_enable = en; if16.in_pop = pop; if16.bypass = byp;
            if16.sync_clr = clr; if16.in_data = d[15:0];
            if64.in_pop = 1'b0; if64.sync_clr = 1'b0;
        end
        @(posedge clk);
        #1;
        if (sel == 0) begin
            ep = if64.out_pop; gd = if64.out_data; gl = if64.out_lock; glk = if64.locked;
        end else begin
            ep = if16.out_pop; gd = {48'h0, if16.out_data}; gl = if16.out_lock; glk = if16.locked;
        end
        chk({tag, ".pop"}, 64'(ep), 64'(acc));
        chk({tag, ".data"}, gd, ed);
        chk({tag, ".lock"}, 64'(gl), 64'(el));
        chk({tag, ".locked"}, 64'(glk), 64'(elk));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".pop64"}, 64'(if64.out_pop), 64'h0);
        chk({tag, ".data64"}, if64.out_data, 64'h0);
        chk({tag, ".lock64"}, 64'(if64.out_lock), 64'h0);
        chk({tag, ".locked64"}, 64'(if64.locked), 64'h0);
        chk({tag, ".pop16"}, 64'(if16.out_pop), 64'h0);
        chk({tag, ".data16"}, 64'(if16.out_data), 64'h0);
        chk({tag, ".locked16"}, 64'(if16.locked), 64'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        if64.in_pop = 1'b0; if64.sync_clr = 1'b0; if64.bypass = 1'b0;
        if16.in_pop = 1'b0; if16.sync_clr = 1'b0; if16.bypass = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
    endtask

    vec_t        vt[9];
    logic [63:0] gd;
    bit          gl, glk;
    logic [63:0] pay;
    logic [15:0] p, sw;
    bit          sc[$];
    bit          b;
    bit          byp;

    initial begin
        reset = 1'b1;
        if64.in_enable = 1'b0; if64.in_pop = 1'b0; if64.in_data = '0;
        if64.bypass = 1'b0; if64.sync_clr = 1'b0;
        if16.in_enable = 1'b0; if16.in_pop = 1'b0; if16.in_data = '0;
        if16.bypass = 1'b0; if16.sync_clr = 1'b0;
        do_reset();

        vt[0] = '{64'h0, 0, 0, 64'h0, 0, 1};
        vt[1] = '{64'h0, 0, 0, 64'h0, 1, 1};
        vt[2] = '{64'h0, 0, 0, 64'h0, 1, 1};
        vt[3] = '{64'h1, 0, 0, 64'h0400_0080_0000_0001, 1, 1};
        vt[4] = '{64'h0, 0, 0, 64'h0, 1, 1};
        vt[5] = '{64'h1, 0, 1, 64'h0400_0080_0000_0001, 0, 1};
        vt[6] = '{64'h0, 0, 0, 64'h0, 1, 1};
        vt[7] = '{64'hDEAD_BEEF_CAFE_F00D, 1, 0, 64'hDEAD_BEEF_CAFE_F00D, 1, 1};
        vt[8] = '{64'h0, 0, 1, 64'h0, 0, 1};
        for (int k = 0; k < 9; k++) begin
            run(0, 1, 1, vt[k].byp, vt[k].clr, vt[k].d, $sformatf("vec%0d", k), gd, gl, glk);
            chk($sformatf("vec%0d.tdata", k), gd, vt[k].ed);
            chk($sformatf("vec%0d.tlock", k), 64'(gl), 64'(vt[k].el));
            chk($sformatf("vec%0d.tlocked", k), 64'(glk), 64'(vt[k].elk));
        end
        // Idle cycle: pulse drops, data and flag hold.
        run(0, 1, 0, 0, 0, 64'h0, "idle64", gd, gl, glk);
        // Clear without accept drops lock.
        run(0, 1, 0, 0, 1, 64'h0, "clr_only", gd, gl, glk);
        chk("clr_only.unlocked", 64'(glk), 64'h0);

        // LFSR-scrambled payload on the 16-bit instance, with bypass and enable gaps mid-stream.
        do_reset();
        for (int i = 0; i < 58; i++) sc.push_back(1'($urandom_range(0, 1)));
        pay = 64'h0123_4567_89AB_CDEF;
        for (int k = 0; k < 20; k++) begin
            if (k == 14) begin
                for (int j = 0; j < 4; j++) begin
                    run(1, 0, 1, 0, 0, 64'($urandom), "en_off", gd, gl, glk);
                    chk("en_off.stay_locked", 64'(glk), 64'h1);
                end
            end
            byp = (k >= 9 && k < 12);
            p = pay[16*(k%4) +: 16];
            for (int i = 0; i < 16; i++) begin
                b = p[i] ^ sc[sc.size()-39] ^ sc[sc.size()-58];
                sc.push_back(b);
                sw[i] = b;
            end
            run(1, 1, 1, byp, 0, 64'(sw), $sformatf("lfsr%0d", k), gd, gl, glk);
            chk($sformatf("lfsr%0d.flag", k), 64'(gl), 64'(k >= 4));
            if (byp) chk($sformatf("lfsr%0d.bypass", k), gd, 64'(sw));
            else if (k >= 4) chk($sformatf("lfsr%0d.payload", k), gd, 64'(p));
        end

        // Asynchronous reset in the middle of a beat.
        run(0, 1, 1, 0, 0, 64'h1, "pre_rst", gd, gl, glk);
        @(negedge clk);
        if64.in_pop = 1'b1; if64.in_data = 64'h5;
        #2 reset = 1'b1;
        #1 check_zero("async_rst");
        @(negedge clk);
        reset = 1'b0;
        if64.in_pop = 1'b0;
        model_reset();
        run(0, 1, 1, 0, 0, 64'h1, "post_rst", gd, gl, glk);
        chk("post_rst.flag", 64'(gl), 64'h0);

        // Randomised traffic on both widths against the reference model.
        for (int k = 0; k < 300; k++) begin
            run(k % 2, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0),
                {$urandom, $urandom}, $sformatf("rnd%0d", k), gd, gl, glk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
